button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioner between the board's raw pushbuttons and slide switches and the SLC-3 core. It synchronizes the active-low Run and Continue keys, debounces each one independently, and gives the core clean active-low levels plus one-cycle press pulses. The 16-bit switch word S is also synchronized and passed to the core's switch input.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized cycles needed to accept a key change (1 ms at 50 MHz); legal range ≥ 2.
- SW_WIDTH, default 16: width of the switch word.

Ports:
- Clk, in, 1: system clock, rising edge. One clock; all state is in this domain.
- Reset, in, 1: synchronous, active-high reset.
- Run_raw, in, 1: raw Run key, active-low, asynchronous and bouncy.
- Continue_raw, in, 1: raw Continue key, active-low, asynchronous and bouncy.
- S_raw, in, SW_WIDTH: raw switch word, asynchronous.
- Run, out, 1: debounced Run level, active-low.
- Continue, out, 1: debounced Continue level, active-low.
- Run_pulse, out, 1: high for one cycle on each accepted Run press (1→0 transition).
- Continue_pulse, out, 1: high for one cycle on each accepted Continue press.
- S, out, SW_WIDTH: synchronized switch word.

## Operation
- Each key has a 2-FF synchronizer (sync1, sync2), a stable register, a counter of width $clog2(DEBOUNCE_CYCLES), and a pulse register.
- Per key, at every edge when Reset is low:
  - sync2 ≠ stable and cnt == DEBOUNCE_CYCLES−1: stable ← sync2 and cnt ← 0. If sync2 is 0, pulse ← 1.
  - sync2 ≠ stable, any other cnt: cnt ← cnt+1 and pulse ← 0.
  - sync2 == stable: cnt ← 0 and pulse ← 0.
- Any bounce back to the stable value clears the count, so only an uninterrupted run of DEBOUNCE_CYCLES mismatching samples is accepted.
- A release (0→1) updates stable and never pulses.
- Run and Continue are fully independent. Simultaneous presses produce simultaneous pulses.
- Per-key state is IDLE (stable=1, cnt=0), ARM_PRESS (stable=1, cnt>0), HELD (stable=0, cnt=0), ARM_RELEASE (stable=0, cnt>0). The FSM is implicit in the stable and cnt registers.
- Switch path: 2-FF synchronizer per bit, with no debounce. S = second stage.
- The counter saturates by construction: it is reset exactly at DEBOUNCE_CYCLES−1 and never wraps.

## Timing
- Reset values:
  - key sync1, sync2 and stable = 1 (released), so Run = Continue = 1.
  - cnt = 0 and pulses = 0.
  - switch sync stages = 0, so S = 0.
- Reset wins over all other activity. A reset in mid-count discards the count.
- After reset, a key still held is debounced from scratch: its first sample is taken at the first edge with Reset low.
- Key latency: if raw changes before edge 0 and stays clean, sync2 updates at edge 1 and stable (Run/Continue) updates at edge DEBOUNCE_CYCLES+1.
- The pulse is asserted in the same cycle the level first reads 0, and deasserts one edge later.
- Switch latency: 2 edges.
- A press shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Holding a key produces exactly one pulse, regardless of hold time.

## Structure
- Shared package button_pkg holds:
  - the key index enum (KEY_RUN=0, KEY_CONTINUE=1);
  - NUM_KEYS=2;
  - the default DEBOUNCE_CYCLES constant.
- Sub-module key_debounce implements one key (synchronizer, counter, stable and pulse registers). It is instantiated NUM_KEYS times.
- The switch synchronizer is inline in button_conditioner.
- Benches override DEBOUNCE_CYCLES to a small value. The core toplevel uses the default.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset held for 3 cycles with Run_raw=Continue_raw=0 and S_raw=FFFF → Run=Continue=1, both pulses 0, S=0000 throughout.
- Run_raw driven 0 and held for 12 cycles → Run falls at edge 5, Run_pulse=1 for exactly that one cycle, Continue and Continue_pulse unchanged.
- Continue_raw 0 for 3 cycles, 1 for 1 cycle, then 0 held → no change until 4 uninterrupted synchronized-low cycles after the bounce; exactly one Continue_pulse.
- Run_raw returned to 1 after a held press → Run rises 5 edges after the change, Run_pulse stays 0. Also drive both raws to 0 on the same edge → both pulses fire in the same cycle.
- S_raw=EEEE, then 1111 ten cycles later → S=EEEE two edges after the first change and 1111 two edges after the second; no glitch values.
- Run_raw 0, then Reset pulsed for 1 cycle at the third cycle → Run stays 1 and cnt clears. Run then falls at edge 5 counted from the first edge after Reset deasserts, with one pulse.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner.
//   key_e                    : index of each debounced key inside the key vectors
//   NUM_KEYS                 : number of debounced keys
//   DEBOUNCE_CYCLES_DEFAULT  : stable cycles required to accept a key change (1 ms at 50 MHz)
package button_pkg;

  typedef enum logic [0:0] {
    KEY_RUN      = 1'b0,
    KEY_CONTINUE = 1'b1
  } key_e;

  localparam int NUM_KEYS                = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchronizer, debounce counter, stable level and
// press pulse.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset (key reads as released)
//   raw   : asynchronous, bouncy key input, active-low
//   level : debounced key level, active-low
//   pulse : one-cycle high on each accepted press (1->0)
// Per-key state (IDLE, ARM_PRESS, HELD, ARM_RELEASE) is held implicitly in the
// stable and cnt registers.
module key_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p1;
  logic             sync_p2;
  logic             stable;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt;

  logic             stable_nxt;
  logic             pulse_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Stage p3: debounce decision on the synchronized sample.
  // Any sample matching the stable level clears the count, so only an
  // uninterrupted run of mismatches reaches CNT_LAST; the count is cleared
  // on acceptance and therefore never wraps.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    pulse_nxt  = 1'b0;
    if (sync_p2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_nxt = sync_p2;
        pulse_nxt  = ~sync_p2;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Stage p1/p2: two-flop synchronizer; p3: stable level, count and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
      stable  <= 1'b1;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_p1 <= raw;
      sync_p2 <= sync_p1;
      stable  <= stable_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign level = stable;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Front-end conditioner between raw board keys/switches and the SLC-3 core.
//   Clk            : system clock, rising edge
//   Reset          : synchronous active-high reset
//   Run_raw        : raw Run key, active-low, asynchronous and bouncy
//   Continue_raw   : raw Continue key, active-low, asynchronous and bouncy
//   S_raw          : raw switch word, asynchronous
//   Run            : debounced Run level, active-low
//   Continue       : debounced Continue level, active-low
//   Run_pulse      : one-cycle pulse on each accepted Run press
//   Continue_pulse : one-cycle pulse on each accepted Continue press
//   S              : synchronized switch word (no debounce)
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_raw,
  input  logic                Continue_raw,
  input  logic [SW_WIDTH-1:0] S_raw,
  output logic                Run,
  output logic                Continue,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic [SW_WIDTH-1:0] S
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_pulse;

  logic [SW_WIDTH-1:0] s_sync_p1;
  logic [SW_WIDTH-1:0] s_sync_p2;

  assign key_raw[KEY_RUN]      = Run_raw;
  assign key_raw[KEY_CONTINUE] = Continue_raw;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (Clk),
      .rst  (Reset),
      .raw  (key_raw[k]),
      .level(key_level[k]),
      .pulse(key_pulse[k])
    );
  end

  // Stage p1/p2: two-flop synchronizer on every switch bit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_sync_p1 <= '0;
      s_sync_p2 <= '0;
    end else begin
      s_sync_p1 <= S_raw;
      s_sync_p2 <= s_sync_p1;
    end
  end

  assign Run            = key_level[KEY_RUN];
  assign Continue       = key_level[KEY_CONTINUE];
  assign Run_pulse      = key_pulse[KEY_RUN];
  assign Continue_pulse = key_pulse[KEY_CONTINUE];
  assign S              = s_sync_p2;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4. The stimulus process
// pushes the expected outputs for every clock edge into a queue; the monitor
// pops one entry per cycle on the falling edge and compares all outputs.
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int SW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Run_raw;
  logic          Continue_raw;
  logic [SW-1:0] S_raw;
  logic          Run;
  logic          Continue;
  logic          Run_pulse;
  logic          Continue_pulse;
  logic [SW-1:0] S;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .SW_WIDTH       (SW)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Run_raw       (Run_raw),
    .Continue_raw  (Continue_raw),
    .S_raw         (S_raw),
    .Run           (Run),
    .Continue      (Continue),
    .Run_pulse     (Run_pulse),
    .Continue_pulse(Continue_pulse),
    .S             (S)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          run;
    logic          cont;
    logic          rp;
    logic          cp;
    logic [SW-1:0] s;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int mon_cyc = 0;

  // Expected steady values, updated by the stimulus as scenarios progress.
  logic          e_run  = 1'b1;
  logic          e_cont = 1'b1;
  logic [SW-1:0] e_s    = '0;

  function automatic void check(input string name, input int cyc,
                                input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endfunction

  // Wait for the next active edge, then queue what the outputs must show.
  task automatic cyc(input logic rp, input logic cp);
    exp_t e;
    @(posedge Clk);
    #1;
    e.run  = e_run;
    e.cont = e_cont;
    e.rp   = rp;
    e.cp   = cp;
    e.s    = e_s;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Monitor: one comparison set per cycle whenever an expectation is queued.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("Run",            mon_cyc, 32'(Run),            32'(e.run));
      check("Continue",       mon_cyc, 32'(Continue),       32'(e.cont));
      check("Run_pulse",      mon_cyc, 32'(Run_pulse),      32'(e.rp));
      check("Continue_pulse", mon_cyc, 32'(Continue_pulse), 32'(e.cp));
      check("S",              mon_cyc, 32'(S),              32'(e.s));
    end
    mon_cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held 3 cycles with keys pressed and switches all ones.
    Reset        = 1'b1;
    Run_raw      = 1'b0;
    Continue_raw = 1'b0;
    S_raw        = 16'hFFFF;
    idle(3);

    Reset        = 1'b0;
    Run_raw      = 1'b1;
    Continue_raw = 1'b1;
    S_raw        = 16'h0000;
    idle(3);

    // Run press held 12 cycles: falls at edge 5 with a single pulse.
    Run_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e_run = (i >= 5) ? 1'b0 : 1'b1;
      cyc(i == 5, 1'b0);
    end

    // Run release: rises at edge 5, never pulses.
    Run_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_run = (i >= 5) ? 1'b1 : 1'b0;
      cyc(1'b0, 1'b0);
    end

    // Continue: 0 for 3 cycles, 1 for 1 cycle, then held 0. The bounce
    // restarts the count, so acceptance lands on edge 9.
    Continue_raw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e_cont = (i >= 9) ? 1'b0 : 1'b1;
      cyc(1'b0, i == 9);
      if (i == 2) Continue_raw = 1'b1;
      if (i == 3) Continue_raw = 1'b0;
    end

    Continue_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_cont = (i >= 5) ? 1'b1 : 1'b0;
      cyc(1'b0, 1'b0);
    end

    // Short press of 3 cycles: no output change.
    Run_raw = 1'b0;
    idle(3);
    Run_raw = 1'b1;
    idle(6);

    // Simultaneous press: both pulses on the same edge.
    Run_raw      = 1'b0;
    Continue_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e_run  = (i >= 5) ? 1'b0 : 1'b1;
      e_cont = (i >= 5) ? 1'b0 : 1'b1;
      cyc(i == 5, i == 5);
    end
    Run_raw      = 1'b1;
    Continue_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_run  = (i >= 5) ? 1'b1 : 1'b0;
      e_cont = (i >= 5) ? 1'b1 : 1'b0;
      cyc(1'b0, 1'b0);
    end

    // Switch path: two-edge latency, no intermediate values.
    S_raw = 16'hEEEE;
    for (int i = 0; i < 10; i++) begin
      e_s = (i >= 1) ? 16'hEEEE : 16'h0000;
      cyc(1'b0, 1'b0);
    end
    S_raw = 16'h1111;
    for (int i = 0; i < 6; i++) begin
      e_s = (i >= 1) ? 16'h1111 : 16'hEEEE;
      cyc(1'b0, 1'b0);
    end

    // Reset in mid-count: count discarded, Run restarts from scratch.
    Run_raw = 1'b0;
    idle(3);
    Reset = 1'b1;
    e_s   = 16'h0000;
    idle(1);
    Reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e_s   = (i >= 1) ? 16'h1111 : 16'h0000;
      e_run = (i >= 5) ? 1'b0 : 1'b1;
      cyc(i == 5, 1'b0);
    end
    Run_raw = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e_run = (i >= 5) ? 1'b1 : 1'b0;
      cyc(1'b0, 1'b0);
    end

    @(negedge Clk);
    #1;
    check("scoreboard_drained", mon_cyc, 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
